rle_encoder_stream: RTL and testbench

- Parametrised successor to the byte-wide, dual-clock run-length encoder.
- Single clock domain. Symbols of DATA_W bits come in on a valid/ready stream.
- Each maximal run goes out as one (count, value) pair on a valid/ready output stream.
- Sits between the capture front-end and the packer/transmit buffer; the explicit end-of-stream marker replaces the old rts-drop flush.

---
 rtl/rle_encoder_stream.sv | 144 ++++++++++++++
 tb/tb_rle_encoder_stream.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rle_encoder_stream.sv
// Streaming run-length encoder: valid/ready symbols in, (count, value) pairs out.
// Define RLE_ENCODER_STATS_EN to build the symbol/pair statistics counters.
module rle_encoder_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] out_value,
  output logic              out_last,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_syms,
  output logic [STAT_W-1:0] stat_pairs
);

  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  run_val, run_val_n;
  logic [CNT_W-1:0]   run_cnt, run_cnt_n;
  logic               emit, emit_last;
  logic [CNT_W-1:0]   emit_cnt;
  logic [DATA_W-1:0]  emit_val;
  logic               slot_free, in_fire;

  // Reset also blocks input so nothing is accepted while the pipeline is being cleared.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rst_n && (state != TAIL) && slot_free;
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    state_n   = state;
    run_val_n = run_val;
    run_cnt_n = run_cnt;
    emit      = 1'b0;
    emit_cnt  = '0;
    emit_val  = '0;
    emit_last = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          run_val_n = in_data;
          if (in_last) begin
            emit      = 1'b1;
            emit_cnt  = ONE;
            emit_val  = in_data;
            emit_last = 1'b1;
          end else begin
            run_cnt_n = ONE;
            state_n   = RUN;
          end
        end
      end
      RUN: begin
        if (in_fire) begin
          if (in_data == run_val && run_cnt != MAXC) begin
            if (in_last) begin
              emit      = 1'b1;
              emit_cnt  = run_cnt + ONE;
              emit_val  = run_val;
              emit_last = 1'b1;
              run_cnt_n = '0;
              state_n   = IDLE;
            end else begin
              run_cnt_n = run_cnt + ONE;
            end
          end else begin
            // Symbol change or saturated count closes the current run.
            emit      = 1'b1;
            emit_cnt  = run_cnt;
            emit_val  = run_val;
            run_val_n = in_data;
            run_cnt_n = ONE;
            if (in_last) state_n = TAIL;
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_cnt  = run_cnt;
          emit_val  = run_val;
          emit_last = 1'b1;
          run_cnt_n = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_val   <= '0;
      run_cnt   <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_value <= '0;
      out_last  <= 1'b0;
    end else begin
      state   <= state_n;
      run_val <= run_val_n;
      run_cnt <= run_cnt_n;
      if (emit) begin
        out_valid <= 1'b1;
        out_count <= emit_cnt;
        out_value <= emit_val;
        out_last  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RLE_ENCODER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_syms  <= '0;
      stat_pairs <= '0;
    end else begin
      if (in_fire) stat_syms  <= stat_syms + STAT_W'(1);
      if (emit)    stat_pairs <= stat_pairs + STAT_W'(1);
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_syms       = '0;
  assign stat_pairs      = '0;
`endif

endmodule

// File: tb/tb_rle_encoder_stream.sv
// Table-driven bench for rle_encoder_stream: one default instance and one with CNT_W=2.
module tb_rle_encoder_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stat_clr;
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_in_data, a_out_count, a_out_value;
  logic [15:0] a_stat_syms, a_stat_pairs;
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_data, b_out_value;
  logic [1:0]  b_out_count;
  logic [15:0] b_stat_syms, b_stat_pairs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rle_encoder_stream u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .out_value(a_out_value), .out_last(a_out_last),
    .stat_clr(stat_clr), .stat_syms(a_stat_syms), .stat_pairs(a_stat_pairs)
  );

  rle_encoder_stream #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_value(b_out_value), .out_last(b_out_last),
    .stat_clr(stat_clr), .stat_syms(b_stat_syms), .stat_pairs(b_stat_pairs)
  );

  typedef struct {
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;
    logic       exp_in_ready;
    logic       exp_valid;
    logic [7:0] exp_count;
    logic [7:0] exp_value;
    logic       exp_last;
  } vec_t;

  function automatic vec_t mk(logic r, logic iv, logic [7:0] d, logic l, logic ordy,
                              logic eir, logic ev, logic [7:0] c, logic [7:0] val, logic el);
    vec_t x;
    x.rst_n = r; x.in_valid = iv; x.in_data = d; x.in_last = l; x.out_ready = ordy;
    x.exp_in_ready = eir; x.exp_valid = ev; x.exp_count = c; x.exp_value = val; x.exp_last = el;
    return x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: in_ready is checked before the edge, out_* after it.
  task automatic apply_stimulus(input vec_t x, input bit use_b, input string tag, input int idx);
    logic       ir, ov, ol;
    logic [7:0] oc, ovl;
    rst_n = x.rst_n;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    if (use_b) begin
      b_in_valid = x.in_valid; b_in_data = x.in_data; b_in_last = x.in_last; b_out_ready = x.out_ready;
    end else begin
      a_in_valid = x.in_valid; a_in_data = x.in_data; a_in_last = x.in_last; a_out_ready = x.out_ready;
    end
    #1;
    ir = use_b ? b_in_ready : a_in_ready;
    check_output($sformatf("%s[%0d] in_ready", tag, idx), 32'(ir), 32'(x.exp_in_ready));
    @(posedge clk);
    #1;
    ov  = use_b ? b_out_valid : a_out_valid;
    oc  = use_b ? {6'd0, b_out_count} : a_out_count;
    ovl = use_b ? b_out_value : a_out_value;
    ol  = use_b ? b_out_last : a_out_last;
    check_output($sformatf("%s[%0d] out_valid", tag, idx), 32'(ov), 32'(x.exp_valid));
    if (x.exp_valid) begin
      check_output($sformatf("%s[%0d] out_count", tag, idx), 32'(oc), 32'(x.exp_count));
      check_output($sformatf("%s[%0d] out_value", tag, idx), 32'(ovl), 32'(x.exp_value));
      check_output($sformatf("%s[%0d] out_last", tag, idx), 32'(ol), 32'(x.exp_last));
    end
  endtask

  initial begin
    vec_t basic[$];
    vec_t stall[$];
    vec_t sat[$];
    vec_t rst_seq[$];

    basic.push_back(mk(1,1,8'hA2,0,1, 1,0,8'h00,8'h00,0));
    basic.push_back(mk(1,1,8'hA2,0,1, 1,0,8'h00,8'h00,0));
    basic.push_back(mk(1,1,8'h01,0,1, 1,1,8'h02,8'hA2,0));
    basic.push_back(mk(1,1,8'hC2,0,1, 1,1,8'h01,8'h01,0));
    basic.push_back(mk(1,1,8'hC2,0,1, 1,0,8'h00,8'h00,0));
    basic.push_back(mk(1,1,8'h3A,0,1, 1,1,8'h02,8'hC2,0));
    basic.push_back(mk(1,1,8'h3A,0,1, 1,0,8'h00,8'h00,0));
    basic.push_back(mk(1,1,8'h3A,0,1, 1,0,8'h00,8'h00,0));
    basic.push_back(mk(1,1,8'h3A,1,1, 1,1,8'h04,8'h3A,1));
    basic.push_back(mk(1,0,8'h00,0,1, 1,0,8'h00,8'h00,0));

    stall.push_back(mk(1,1,8'h11,0,0, 1,0,8'h00,8'h00,0));
    stall.push_back(mk(1,1,8'h22,0,0, 1,1,8'h01,8'h11,0));
    for (int i = 0; i < 8; i++) stall.push_back(mk(1,1,8'h11,0,0, 0,1,8'h01,8'h11,0));
    stall.push_back(mk(1,1,8'h11,0,1, 1,1,8'h01,8'h22,0));
    stall.push_back(mk(1,1,8'h22,1,1, 1,1,8'h01,8'h11,0));
    stall.push_back(mk(1,0,8'h00,0,1, 0,1,8'h01,8'h22,1));
    stall.push_back(mk(1,0,8'h00,0,1, 1,0,8'h00,8'h00,0));

    sat.push_back(mk(1,1,8'h55,0,1, 1,0,8'h00,8'h00,0));
    sat.push_back(mk(1,1,8'h55,0,1, 1,0,8'h00,8'h00,0));
    sat.push_back(mk(1,1,8'h55,0,1, 1,0,8'h00,8'h00,0));
    sat.push_back(mk(1,1,8'h55,0,1, 1,1,8'h03,8'h55,0));
    sat.push_back(mk(1,1,8'h55,1,1, 1,1,8'h02,8'h55,1));
    sat.push_back(mk(1,1,8'h10,0,1, 1,0,8'h00,8'h00,0));
    sat.push_back(mk(1,1,8'h20,1,1, 1,1,8'h01,8'h10,0));
    sat.push_back(mk(1,0,8'h00,0,1, 0,1,8'h01,8'h20,1));
    sat.push_back(mk(1,0,8'h00,0,1, 1,0,8'h00,8'h00,0));

    rst_seq.push_back(mk(1,1,8'hEE,0,1, 1,0,8'h00,8'h00,0));
    rst_seq.push_back(mk(1,1,8'hEE,0,1, 1,0,8'h00,8'h00,0));
    rst_seq.push_back(mk(1,1,8'hEE,0,1, 1,0,8'h00,8'h00,0));
    rst_seq.push_back(mk(1,1,8'h01,0,0, 1,1,8'h03,8'hEE,0));
    rst_seq.push_back(mk(0,0,8'h00,0,0, 0,0,8'h00,8'h00,0));
    rst_seq.push_back(mk(1,1,8'h01,1,1, 1,1,8'h01,8'h01,1));
    rst_seq.push_back(mk(1,0,8'h00,0,1, 1,0,8'h00,8'h00,0));

    rst_n = 1'b0; stat_clr = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset in_ready", 32'(a_in_ready), 32'd0);
    check_output("reset out_valid", 32'(a_out_valid), 32'd0);
    check_output("reset out_count", 32'(a_out_count), 32'd0);
    check_output("reset out_value", 32'(a_out_value), 32'd0);
    check_output("reset out_last", 32'(a_out_last), 32'd0);
    check_output("reset stat_syms", 32'(a_stat_syms), 32'd0);

    foreach (basic[i]) apply_stimulus(basic[i], 1'b0, "basic", i);
`ifdef RLE_ENCODER_STATS_EN
    check_output("stat_syms after basic", 32'(a_stat_syms), 32'd9);
    check_output("stat_pairs after basic", 32'(a_stat_pairs), 32'd4);
`else
    check_output("stat_syms tied", 32'(a_stat_syms), 32'd0);
    check_output("stat_pairs tied", 32'(a_stat_pairs), 32'd0);
`endif

    // Lone last symbol in IDLE, with a statistics clear on the same transfer.
    stat_clr = 1'b1;
    apply_stimulus(mk(1,1,8'h7F,1,1, 1,1,8'h01,8'h7F,1), 1'b0, "single", 0);
    stat_clr = 1'b0;
    check_output("stat_syms after clr", 32'(a_stat_syms), 32'd0);
    check_output("stat_pairs after clr", 32'(a_stat_pairs), 32'd0);
    apply_stimulus(mk(1,0,8'h00,0,1, 1,0,8'h00,8'h00,0), 1'b0, "single", 1);

    foreach (stall[i]) apply_stimulus(stall[i], 1'b0, "stall", i);
    foreach (rst_seq[i]) apply_stimulus(rst_seq[i], 1'b0, "midreset", i);
    foreach (sat[i]) apply_stimulus(sat[i], 1'b1, "saturate", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
